// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Pipeline sequencing controller for the 5-stage core
//   (PC / IF_ID / ID_EX / EX_MEM / MEM_WB).
//
//   - Detects load-use hazards between the instruction in ID and a load in EX.
//     It stalls PC/IF_ID and injects NOP bubbles through the CU_mux.
//   - Handles taken branches. It redirects the PC, squashes IF_ID, and then
//     forces one bubble while the squashed word sits in ID.
//   - Selects the operand forwarding source for EX.
//
// Configuration macro: HAZARD_PERF_CNT_EN
//   When defined, this block adds saturating stall and flush counters.
//   When undefined, stall_cnt and flush_cnt are tied to zero.
//
// Ports
//   clk            pipeline clock, rising edge
//   R              asynchronous, active-high reset
//   ID_rn, ID_rm   source registers of the ID instruction
//   ID_use_rn/rm   ID instruction actually reads Rn / Rm
//   branch_taken   ID holds a taken B/BL
//   EX_*           load flag, RF write enable and destination of EX
//   MEM_*, WB_*    RF write enable and destination of MEM / WB
//   LE             PC and IF_ID load enable (0 = hold)
//   ifid_clr       squash IF_ID at the next edge
//   pc_sel         1 = PC loads the branch target
//   S              1 = CU_mux forces a NOP into ID_EX
//   fwd_a, fwd_b   operand source: 00 RF, 01 EX, 10 MEM, 11 WB
//   stall_cnt      stall cycles since reset
//   flush_cnt      branch flushes since reset
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int REG_W        = 4,
  parameter int STALL_CYCLES = 1,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              R,
  input  logic [REG_W-1:0]  ID_rn,
  input  logic [REG_W-1:0]  ID_rm,
  input  logic              ID_use_rn,
  input  logic              ID_use_rm,
  input  logic              branch_taken,
  input  logic              EX_load_instr,
  input  logic              EX_RF_enable,
  input  logic [REG_W-1:0]  EX_rd,
  input  logic              MEM_RF_enable,
  input  logic [REG_W-1:0]  MEM_rd,
  input  logic              WB_RF_enable,
  input  logic [REG_W-1:0]  WB_rd,
  output logic              LE,
  output logic              ifid_clr,
  output logic              pc_sel,
  output logic              S,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STALL_CYCLES - 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_BR_FLUSH = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] bub_cnt_r;
  logic [CNT_W-1:0] bub_cnt_nxt_s;
  logic             lu_hit_s;
  logic             le_s;
  logic             s_s;
  logic             pc_sel_s;
  logic             ifid_clr_s;
  logic             ex_fwd_en_s;

  // Priority forwarding select. The youngest producer wins.
  // An unused operand always reads the RF.
  function automatic logic [1:0] fwd_sel(
    input logic             use_x,
    input logic [REG_W-1:0] rs,
    input logic             ex_en,
    input logic [REG_W-1:0] ex_rd,
    input logic             mem_en,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_en,
    input logic [REG_W-1:0] wb_rd
  );
    logic [1:0] sel;
    if (!use_x)                        sel = 2'b00;
    else if (ex_en  && (rs == ex_rd))  sel = 2'b01;
    else if (mem_en && (rs == mem_rd)) sel = 2'b10;
    else if (wb_en  && (rs == wb_rd))  sel = 2'b11;
    else                               sel = 2'b00;
    return sel;
  endfunction

  assign lu_hit_s = EX_load_instr & EX_RF_enable &
                    ((ID_use_rn & (ID_rn == EX_rd)) | (ID_use_rm & (ID_rm == EX_rd)));

  // A load result is not ready in EX, so EX is never a forwarding source for a load.
  assign ex_fwd_en_s = EX_RF_enable & ~EX_load_instr;

  // FSM next state and control outputs. Reset overrides everything combinationally.
  always_comb begin
    state_nxt_s   = state_r;
    bub_cnt_nxt_s = bub_cnt_r;
    le_s          = 1'b1;
    s_s           = 1'b0;
    pc_sel_s      = 1'b0;
    ifid_clr_s    = 1'b0;
    if (R) begin
      state_nxt_s   = ST_RUN;
      bub_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (lu_hit_s) begin
            le_s = 1'b0;
            s_s  = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_nxt_s   = ST_LU_STALL;
              bub_cnt_nxt_s = CNT_LOAD;
            end else begin
              state_nxt_s   = ST_RUN;
            end
          end else if (branch_taken) begin
            pc_sel_s    = 1'b1;
            ifid_clr_s  = 1'b1;
            state_nxt_s = ST_BR_FLUSH;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_LU_STALL: begin
          le_s          = 1'b0;
          s_s           = 1'b1;
          bub_cnt_nxt_s = bub_cnt_r - CNT_ONE;
          if (bub_cnt_r == CNT_ONE) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_LU_STALL;
          end
        end
        ST_BR_FLUSH: begin
          // The squashed all-zero word in ID must not produce control signals.
          s_s         = 1'b1;
          state_nxt_s = ST_RUN;
        end
        default: begin
          state_nxt_s   = ST_RUN;
          bub_cnt_nxt_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state and bubble counter registers.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_r   <= ST_RUN;
      bub_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      bub_cnt_r <= bub_cnt_nxt_s;
    end
  end

  assign LE       = le_s;
  assign S        = s_s;
  assign pc_sel   = pc_sel_s;
  assign ifid_clr = ifid_clr_s;
  assign fwd_a    = R ? 2'b00 : fwd_sel(ID_use_rn, ID_rn, ex_fwd_en_s, EX_rd,
                                        MEM_RF_enable, MEM_rd, WB_RF_enable, WB_rd);
  assign fwd_b    = R ? 2'b00 : fwd_sel(ID_use_rm, ID_rm, ex_fwd_en_s, EX_rd,
                                        MEM_RF_enable, MEM_rd, WB_RF_enable, WB_rd);

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_r;
  logic [PERF_W-1:0] flush_cnt_r;

  // Saturating performance counters for stall cycles and branch flushes.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      stall_cnt_r <= {PERF_W{1'b0}};
      flush_cnt_r <= {PERF_W{1'b0}};
    end else begin
      if (!le_s && (stall_cnt_r != {PERF_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if ((state_r == ST_RUN) && (state_nxt_s == ST_BR_FLUSH) &&
          (flush_cnt_r != {PERF_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {PERF_W{1'b0}};
  assign flush_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Self-checking bench for hazard_fwd_ctrl. It drives two instances from the
//   same inputs:
//     unit 0: STALL_CYCLES=1, PERF_W=16
//     unit 1: STALL_CYCLES=3, PERF_W=4 (so the saturating counter limit is reached)
//   A reference model tracks "bubbles still owed" and "flush pending" for each unit.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       R;
  logic [3:0] ID_rn, ID_rm, EX_rd, MEM_rd, WB_rd;
  logic       ID_use_rn, ID_use_rm, branch_taken, EX_load_instr;
  logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable;

  logic [1:0]  le_v, clr_v, pcs_v, s_v;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;

  int tests = 0;
  int fails = 0;

  int m_left  [2];
  bit m_flush [2];
  int m_sc    [2];
  int m_fc    [2];
  int stalls  [2] = '{1, 3};
  int sat     [2] = '{65535, 15};

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.REG_W(4), .STALL_CYCLES(1), .PERF_W(16)) u0 (
    .clk(clk), .R(R), .ID_rn(ID_rn), .ID_rm(ID_rm), .ID_use_rn(ID_use_rn),
    .ID_use_rm(ID_use_rm), .branch_taken(branch_taken), .EX_load_instr(EX_load_instr),
    .EX_RF_enable(EX_RF_enable), .EX_rd(EX_rd), .MEM_RF_enable(MEM_RF_enable),
    .MEM_rd(MEM_rd), .WB_RF_enable(WB_RF_enable), .WB_rd(WB_rd),
    .LE(le_v[0]), .ifid_clr(clr_v[0]), .pc_sel(pcs_v[0]), .S(s_v[0]),
    .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_fwd_ctrl #(.REG_W(4), .STALL_CYCLES(3), .PERF_W(4)) u1 (
    .clk(clk), .R(R), .ID_rn(ID_rn), .ID_rm(ID_rm), .ID_use_rn(ID_use_rn),
    .ID_use_rm(ID_use_rm), .branch_taken(branch_taken), .EX_load_instr(EX_load_instr),
    .EX_RF_enable(EX_RF_enable), .EX_rd(EX_rd), .MEM_RF_enable(MEM_RF_enable),
    .MEM_rd(MEM_rd), .WB_RF_enable(WB_RF_enable), .WB_rd(WB_rd),
    .LE(le_v[1]), .ifid_clr(clr_v[1]), .pc_sel(pcs_v[1]), .S(s_v[1]),
    .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

  task automatic chk(input string tag, input int unit, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s u%0d observed=%0h expected=%0h", tag, unit, obs, exp);
    end
  endtask

  // Operand source as the model sees it. Producers are scanned youngest first.
  function automatic logic [1:0] model_fwd(input logic use_x, input logic [3:0] rs);
    logic       en [3];
    logic [3:0] rd [3];
    en[0] = EX_RF_enable && !EX_load_instr; rd[0] = EX_rd;
    en[1] = MEM_RF_enable;                  rd[1] = MEM_rd;
    en[2] = WB_RF_enable;                   rd[2] = WB_rd;
    if (R || !use_x) return 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (en[i] && rd[i] == rs) return 2'(i + 1);
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_flush[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // Check one cycle of both units against the model, then advance across one clock edge.
  task automatic step(input string tag);
    logic lu;
    logic e_le [2];
    logic e_s  [2];
    logic e_br [2];
    logic [31:0] o_sc, o_fc, x_sc, x_fc;
    #1;
    if (R) model_reset();
    lu = EX_load_instr && EX_RF_enable &&
         ((ID_use_rn && ID_rn == EX_rd) || (ID_use_rm && ID_rm == EX_rd));
    for (int k = 0; k < 2; k++) begin
      e_le[k] = 1'b1; e_s[k] = 1'b0; e_br[k] = 1'b0;
      if (R) begin
      end else if (m_left[k] > 0) begin
        e_le[k] = 1'b0; e_s[k] = 1'b1;
      end else if (m_flush[k]) begin
        e_s[k] = 1'b1;
      end else if (lu) begin
        e_le[k] = 1'b0; e_s[k] = 1'b1;
      end else if (branch_taken) begin
        e_br[k] = 1'b1;
      end
      chk({tag, ".LE"}, k, 32'(le_v[k]), 32'(e_le[k]));
      chk({tag, ".S"}, k, 32'(s_v[k]), 32'(e_s[k]));
      chk({tag, ".pc_sel"}, k, 32'(pcs_v[k]), 32'(e_br[k]));
      chk({tag, ".ifid_clr"}, k, 32'(clr_v[k]), 32'(e_br[k]));
      chk({tag, ".fwd_a"}, k, 32'(k == 0 ? fa0 : fa1), 32'(model_fwd(ID_use_rn, ID_rn)));
      chk({tag, ".fwd_b"}, k, 32'(k == 0 ? fb0 : fb1), 32'(model_fwd(ID_use_rm, ID_rm)));
      o_sc = (k == 0) ? 32'(sc0) : 32'(sc1);
      o_fc = (k == 0) ? 32'(fc0) : 32'(fc1);
`ifdef HAZARD_PERF_CNT_EN
      x_sc = 32'(m_sc[k]); x_fc = 32'(m_fc[k]);
`else
      x_sc = 32'd0; x_fc = 32'd0;
`endif
      chk({tag, ".stall_cnt"}, k, o_sc, x_sc);
      chk({tag, ".flush_cnt"}, k, o_fc, x_fc);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (R) begin
        m_left[k] = 0; m_flush[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        if (!e_le[k] && m_sc[k] < sat[k]) m_sc[k]++;
        if (m_left[k] > 0) m_left[k]--;
        else if (m_flush[k]) m_flush[k] = 1'b0;
        else if (lu) m_left[k] = stalls[k] - 1;
        else if (branch_taken) begin
          m_flush[k] = 1'b1;
          if (m_fc[k] < sat[k]) m_fc[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    ID_rn = 4'd0; ID_rm = 4'd0; ID_use_rn = 1'b0; ID_use_rm = 1'b0;
    branch_taken = 1'b0; EX_load_instr = 1'b0; EX_RF_enable = 1'b0; EX_rd = 4'd0;
    MEM_RF_enable = 1'b0; MEM_rd = 4'd0; WB_RF_enable = 1'b0; WB_rd = 4'd0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    R = 1'b1;
    // Reset held across several edges, then released.
    step("reset"); step("reset"); step("reset");
    R = 1'b0;
    step("run_idle");

    // Load-use on Rn. The load then moves to MEM and is forwarded.
    EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = 4'd2;
    ID_rn = 4'd2; ID_use_rn = 1'b1;
    step("lu_hit");
    EX_load_instr = 1'b0; EX_RF_enable = 1'b0;
    MEM_RF_enable = 1'b1; MEM_rd = 4'd2;
    step("lu_fwd_mem");
    step("lu_stall3");
    step("lu_after");
    idle_inputs();
    step("idle");

    // Taken branch. branch_taken stays high during the flush cycle and must be ignored there.
    branch_taken = 1'b1;
    step("br_take");
    step("br_flush");
    branch_taken = 1'b0;
    step("br_after");

    // Forwarding priority: EX, then MEM, then WB.
    EX_rd = 4'd5; MEM_rd = 4'd5; WB_rd = 4'd5;
    EX_RF_enable = 1'b1; MEM_RF_enable = 1'b1; WB_RF_enable = 1'b1;
    ID_rm = 4'd5; ID_use_rm = 1'b1;
    step("fwd_ex");
    EX_RF_enable = 1'b0;
    step("fwd_mem");
    MEM_RF_enable = 1'b0;
    step("fwd_wb");
    ID_use_rm = 1'b0;
    step("fwd_unused");
    idle_inputs();

    // Reset asserted mid-cycle while unit 1 is in LU_STALL with two bubbles still owed.
    EX_load_instr = 1'b1; EX_RF_enable = 1'b1; EX_rd = 4'd7;
    ID_rm = 4'd7; ID_use_rm = 1'b1;
    step("lu_hit2");
    idle_inputs();
    #2;
    R = 1'b1;
    step("reset_mid_stall");
    #2;
    R = 1'b0;
    step("reset_released");

    // Randomized traffic. Small register numbers keep hazards and matches frequent.
    for (int n = 0; n < 600; n++) begin
      R             = ($urandom_range(0, 63) == 0);
      ID_rn         = 4'($urandom_range(0, 3));
      ID_rm         = 4'($urandom_range(0, 3));
      ID_use_rn     = 1'($urandom);
      ID_use_rm     = 1'($urandom);
      branch_taken  = ($urandom_range(0, 3) == 0);
      EX_load_instr = 1'($urandom);
      EX_RF_enable  = 1'($urandom);
      EX_rd         = 4'($urandom_range(0, 3));
      MEM_RF_enable = 1'($urandom);
      MEM_rd        = 4'($urandom_range(0, 3));
      WB_RF_enable  = 1'($urandom);
      WB_rd         = 4'($urandom_range(0, 3));
      step("rand");
    end
    R = 1'b0;
    idle_inputs();
    step("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
